// File: rtl/lzx_updown_cnt4.sv
// 4-bit synchronous up/down counter with parallel load, cascade carry/borrow and sticky overflow.
// Define LZX_CNT_SAT_EN to saturate at 15/0 instead of wrapping.
module lzx_updown_cnt4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] D,
    input  logic       en,
    input  logic       cen,
    input  logic       up,
    output logic [3:0] Q,
    output logic       CO,
    output logic       BO,
    output logic       ovf
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       ovf_q;
    logic       ovf_d;
    logic [3:0] q_eff;
    logic       term;

    // Terminal counts see Q as already reset while rst is high, so CO cannot
    // fire into the next stage during reset.
    assign q_eff = rst ? 4'd0 : q_q;
    assign CO    = en & cen & up & (q_eff == 4'hF);
    assign BO    = en & cen & ~up & (q_eff == 4'h0);
    assign term  = CO | BO;

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (load) begin
            q_d   = D;
            ovf_d = 1'b0;
        end else if (en && cen) begin
            if (term) begin
                ovf_d = 1'b1;
            end
`ifdef LZX_CNT_SAT_EN
            if (!term) begin
                q_d = up ? q_q + 4'd1 : q_q - 4'd1;
            end
`else
            q_d = up ? q_q + 4'd1 : q_q - 4'd1;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_lzx_updown_cnt4.sv
// Self-checking bench for lzx_updown_cnt4: scoreboard of expected Q/ovf per edge,
// direct checks of combinational CO/BO, plus a two-stage cascade.
module tb_lzx_updown_cnt4;

    typedef struct packed {
        logic [3:0] q;
        logic       ovf;
    } st_t;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, load, en, cen, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       co, bo, ovf;

    // cascade pair
    logic       c_rst, c_load, c_en, c_up;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_co, lo_bo, hi_co, hi_bo, lo_ovf, hi_ovf;
    logic       hi_cen;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    st_t  m;
    st_t  m_lo, m_hi;

    always #5 clk = ~clk;

    lzx_updown_cnt4 dut (
        .clk(clk), .rst(rst), .load(load), .D(d), .en(en), .cen(cen), .up(up),
        .Q(q), .CO(co), .BO(bo), .ovf(ovf)
    );

    assign hi_cen = c_up ? lo_co : lo_bo;

    lzx_updown_cnt4 u_lo (
        .clk(clk), .rst(c_rst), .load(c_load), .D(c_d[3:0]), .en(c_en), .cen(1'b1), .up(c_up),
        .Q(lo_q), .CO(lo_co), .BO(lo_bo), .ovf(lo_ovf)
    );

    lzx_updown_cnt4 u_hi (
        .clk(clk), .rst(c_rst), .load(c_load), .D(c_d[7:4]), .en(c_en), .cen(hi_cen), .up(c_up),
        .Q(hi_q), .CO(hi_co), .BO(hi_bo), .ovf(hi_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic co_f(st_t s, logic r, logic e, logic c, logic u);
        return e & c & u & (!r && s.q == 4'hF);
    endfunction

    function automatic logic bo_f(st_t s, logic r, logic e, logic c, logic u);
        return e & c & ~u & (r ? 1'b1 : (s.q == 4'h0));
    endfunction

    function automatic st_t next_f(st_t s, logic r, logic l, logic [3:0] dv,
                                   logic e, logic c, logic u);
        st_t  n;
        logic at_end;
        n = s;
        at_end = u ? (s.q == 4'hF) : (s.q == 4'h0);
        if (r) begin
            n = '0;
        end else if (l) begin
            n.q   = dv;
            n.ovf = 1'b0;
        end else if (e && c) begin
            if (at_end) n.ovf = 1'b1;
`ifdef LZX_CNT_SAT_EN
            if (!at_end) n.q = u ? s.q + 4'd1 : s.q - 4'd1;
`else
            n.q = u ? s.q + 4'd1 : s.q - 4'd1;
`endif
        end
        return n;
    endfunction

    task automatic drive(input logic r, input logic l, input logic [3:0] dv,
                         input logic e, input logic c, input logic u);
        rst = r; load = l; d = dv; en = e; cen = c; up = u;
    endtask

    task automatic tick(input string tag);
        exp_t x;
        st_t  n;
        #1;
        check({tag, "_co"}, {31'd0, co}, {31'd0, co_f(m, rst, en, cen, up)});
        check({tag, "_bo"}, {31'd0, bo}, {31'd0, bo_f(m, rst, en, cen, up)});
        n = next_f(m, rst, load, d, en, cen, up);
        x.tag = tag; x.q = {4'h0, n.q}; x.ovf = n.ovf;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.tag, "_q"}, {28'd0, q}, {24'd0, x.q});
        check({x.tag, "_ovf"}, {31'd0, ovf}, {31'd0, x.ovf});
        m = n;
    endtask

    task automatic ctick(input string tag);
        exp_t x;
        st_t  n_lo, n_hi;
        logic h_cen;
        h_cen = c_up ? co_f(m_lo, c_rst, c_en, 1'b1, c_up) : bo_f(m_lo, c_rst, c_en, 1'b1, c_up);
        n_lo = next_f(m_lo, c_rst, c_load, c_d[3:0], c_en, 1'b1, c_up);
        n_hi = next_f(m_hi, c_rst, c_load, c_d[7:4], c_en, h_cen, c_up);
        x.tag = tag; x.q = {n_hi.q, n_lo.q}; x.ovf = n_hi.ovf;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.tag, "_q8"}, {24'd0, hi_q, lo_q}, {24'd0, x.q});
        m_lo = n_lo;
        m_hi = n_hi;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m = '0; m_lo = '0; m_hi = '0;
        c_rst = 1'b1; c_load = 1'b0; c_d = 8'h00; c_en = 1'b0; c_up = 1'b1;
        drive(1, 0, 4'h0, 1, 1, 1);
        @(negedge clk);
        tick("rst_up");                       // CO forced low during reset
        drive(1, 0, 4'h0, 1, 1, 0);
        tick("rst_dn");                       // BO follows Q=0 during reset
        drive(0, 1, 4'hA, 0, 0, 1);
        tick("load_a");

        drive(0, 1, 4'hE, 0, 0, 1);
        tick("ld_e");
        drive(0, 0, 4'h0, 1, 1, 1);
        repeat (3) tick("up_wrap");

        drive(0, 1, 4'h1, 0, 0, 1);
        tick("ld_1");
        drive(0, 0, 4'h0, 1, 1, 0);
        repeat (3) tick("dn_wrap");

        drive(0, 0, 4'h0, 0, 1, 1);
        repeat (2) tick("ovf_sticky");
        drive(0, 0, 4'h0, 1, 1, 1);
        tick("to_f");
        drive(0, 1, 4'h3, 1, 1, 1);
        tick("prec_load");
        drive(0, 1, 4'hF, 0, 0, 1);
        tick("ld_f");
        drive(1, 1, 4'h3, 1, 1, 1);
        tick("prec_rst");

        drive(0, 1, 4'h9, 0, 0, 1);
        tick("ld_9");
        drive(0, 0, 4'h0, 1, 0, 1);
        repeat (4) tick("hold_cen0");

        drive(0, 1, 4'h5, 0, 0, 1);
        tick("ld_5");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'h0, 1, 1, (i % 2) == 0);
            tick("toggle");
        end

        drive(0, 0, 4'h0, 1, 1, 1);
        repeat (2) tick("pre_abort");
        drive(1, 0, 4'h0, 1, 1, 1);
        tick("abort_rst");
        drive(0, 0, 4'h0, 1, 1, 1);
        tick("first_step");

        c_rst = 1'b0; c_load = 1'b1; c_d = 8'h0F; c_en = 1'b0; c_up = 1'b1;
        ctick("c_ld_0f");
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        ctick("c_up");
        c_load = 1'b1; c_d = 8'h00; c_en = 1'b0;
        ctick("c_ld_00");
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b0;
        ctick("c_dn");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
